// File: rtl/ppu_pkg.sv
// Shared PPU package.
// Holds the register-level types used across the PPU slice (LCDC bit
// layout, PPU register map) together with the OAM DMA state encoding and
// the echo-RAM remapping constants used by the DMA source-page logic.
package ppu_pkg;

   // LCDC register bit layout, MSB first.
   typedef struct packed {
      logic lcd_en;
      logic win_map;
      logic win_en;
      logic tile_sel;
      logic bg_map;
      logic obj_size;
      logic obj_en;
      logic bg_en;
   } lcdc_t;

   // Low byte of the PPU register addresses in the 0xFF40 page.
   typedef enum logic [7:0] {
      REG_LCDC = 8'h40,
      REG_STAT = 8'h41,
      REG_SCY  = 8'h42,
      REG_SCX  = 8'h43,
      REG_LY   = 8'h44,
      REG_LYC  = 8'h45,
      REG_DMA  = 8'h46,
      REG_BGP  = 8'h47,
      REG_OBP0 = 8'h48,
      REG_OBP1 = 8'h49,
      REG_WY   = 8'h4A,
      REG_WX   = 8'h4B
   } ppu_reg_t;

   // OAM DMA controller states.
   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_DELAY = 2'd1,
      DMA_COPY  = 2'd2,
      DMA_DRAIN = 2'd3
   } dma_state_t;

   // Pages at or above 0xE0 are echo RAM and alias 0x20 pages lower.
   localparam logic [7:0] DMA_ECHO_BASE   = 8'hE0;
   localparam logic [7:0] DMA_ECHO_OFFSET = 8'h20;

   function automatic logic [7:0] dma_src_page(input logic [7:0] hi);
      return (hi >= DMA_ECHO_BASE) ? (hi - DMA_ECHO_OFFSET) : hi;
   endfunction

endpackage

// File: rtl/oam_dma_delay_ctr.sv
// dma_delay_ctr: ce-gated down-counter with a done flag.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   load, load_val reload the counter (load wins over counting)
//   en             counting enabled (owner is in its waiting state)
//   ce             M-cycle strobe; the counter only moves on ce cycles
//   done           high on the ce cycle that completes the count
// A load value of 0 behaves like 1: the wait always lasts at least one
// ce cycle.
module dma_delay_ctr #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         ce,
   output logic         done
);

   logic [W-1:0] cnt;

   assign done = en && ce && !load && (cnt <= W'(1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && ce && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

endmodule

// File: rtl/oam_dma.sv
// oam_dma: copies LENGTH bytes from page {src_hi,00} into OAM, one byte
// per M-cycle (ce strobe), after START_DELAY idle M-cycles.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   ce                 M-cycle strobe
//   start, src_hi      DMA register write pulse and source page
//   mem_addr, mem_rd   source read request (combinational, ce cycles only)
//   mem_d_in           read data, valid one clk after mem_rd
//   oam_addr, oam_d_wr OAM write address/data, meaningful with oam_write
//   oam_write          OAM write strobe, one clk after each read
//   busy               CPU bus lockout
//   state              current FSM state (debug)
// Outputs are gated by rst so that asserting reset silences the block in
// the same clk, not only after the next edge.
module oam_dma
   import ppu_pkg::*;
#(
   parameter int LENGTH      = 160,
   parameter int START_DELAY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        start,
   input  logic [7:0]  src_hi,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_d_in,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_d_wr,
   output logic        oam_write,
   output logic        busy,
   output dma_state_t  state
);

   localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

   dma_state_t state_q;
   logic [7:0] idx_q;
   logic [7:0] page_q;
   logic [7:0] oam_addr_q;
   logic       wr_pend_q;
   logic       step;
   logic       delay_done;

   // A start arriving on a COPY ce cycle wins: no read is issued then.
   assign step = rst && ce && !start && (state_q == DMA_COPY);

   dma_delay_ctr #(
      .W(16)
   ) u_delay (
      .clk     (clk),
      .rst     (rst),
      .load    (start),
      .load_val(16'(START_DELAY)),
      .en      (state_q == DMA_DELAY),
      .ce      (ce),
      .done    (delay_done)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= DMA_IDLE;
         idx_q      <= '0;
         wr_pend_q  <= 1'b0;
         oam_addr_q <= '0;
      end else begin
         // The write for a read already issued always completes, even
         // across a restart or a ce stall.
         wr_pend_q <= step;
         if (step) oam_addr_q <= idx_q;

         if (start) begin
            state_q <= DMA_DELAY;
            idx_q   <= '0;
         end else begin
            case (state_q)
               DMA_DELAY: if (delay_done) state_q <= DMA_COPY;
               DMA_COPY: begin
                  if (step) begin
                     if (idx_q == LAST_IDX) begin
                        state_q <= DMA_DRAIN;
                        idx_q   <= '0;
                     end else begin
                        idx_q <= idx_q + 8'd1;
                     end
                  end
               end
               DMA_DRAIN: state_q <= DMA_IDLE;
               default: ;
            endcase
         end
      end
   end

   // The source page carries no reset; it is always reloaded by start
   // before it is used.
   always_ff @(posedge clk) begin
      if (start) page_q <= dma_src_page(src_hi);
   end

   assign mem_rd    = step;
   assign mem_addr  = step ? {page_q, idx_q} : 16'h0000;
   assign oam_write = rst && wr_pend_q;
   assign oam_addr  = rst ? oam_addr_q : 8'h00;
   assign oam_d_wr  = oam_write ? mem_d_in : 8'h00;
   // The final write always happens in DRAIN, so busy covers it.
   assign busy      = rst && (state_q != DMA_IDLE);
   assign state     = rst ? state_q : DMA_IDLE;

endmodule
